memory: RTL and testbench

MEMORY -- requirements
Module: memory

---
 rtl/memory_if.sv | 21 ++
 rtl/memory.sv | 191 +++++++++++++++++++
 tb/tb_memory.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_if.sv
// Data bus between the MEM stage and data memory.
// Address/strobe/wdata are valid while mem_req is high; rdata is valid with mem_ack.
interface memory_if;
  logic        mem_req;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_strobe;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_write, mem_addr, mem_wdata, mem_strobe,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_write, mem_addr, mem_wdata, mem_strobe,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/memory.sv
// MEM pipeline stage: data bus access FSM and MEM/WB register.
// Define MISALIGNED_TRAP_EN to trap misaligned half/word accesses.
module memory (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic [31:0] next_pc_in,
  input  logic [31:0] alu_data_in,
  input  logic [31:0] rs2_data_in,
  input  logic [31:0] csr_data_in,
  input  logic        branch_taken_in,
  input  logic        load_in,
  input  logic        store_in,
  input  logic        load_signed_in,
  input  logic        mret_in,
  input  logic        wfi_in,
  input  logic        exception_in,
  input  logic [1:0]  load_store_size_in,
  input  logic [1:0]  write_select_in,
  input  logic [4:0]  rd_address_in,
  input  logic [11:0] csr_address_in,
  input  logic [3:0]  ecause_in,
  input  logic        valid_in,
  input  logic        stall,
  input  logic        invalidate,
  output logic        mem_busy,
  memory_if.master    bus,
  output logic [31:0] pc_out,
  output logic [31:0] next_pc_out,
  output logic [31:0] alu_data_out,
  output logic [31:0] csr_data_out,
  output logic [31:0] load_data_out,
  output logic        branch_taken_out,
  output logic        mret_out,
  output logic        wfi_out,
  output logic        valid_out,
  output logic        exception_out,
  output logic [1:0]  write_select_out,
  output logic [4:0]  rd_address_out,
  output logic [11:0] csr_address_out,
  output logic [3:0]  ecause_out
);

  typedef enum logic {IDLE, WAIT} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [31:0] alu;
    logic [31:0] csr;
    logic [31:0] load_data;
    logic        branch;
    logic        mret;
    logic        wfi;
    logic        valid;
    logic        exc;
    logic [1:0]  wsel;
    logic [4:0]  rd;
    logic [11:0] csra;
    logic [3:0]  ecause;
  } wb_t;

  state_t      state_q, state_d;
  logic        done_q, done_d;
  logic [31:0] held_q, held_d;
  wb_t         wb_q, wb_d;

  logic        is_byte, is_half, is_word;
  logic [1:0]  off;
  logic        misaligned, mis_trap, start;
  logic        ack_hit, capture;
  logic [31:0] shifted, ext, load_data;

  assign is_byte = load_store_size_in == 2'd0;
  assign is_half = load_store_size_in == 2'd1;
  assign is_word = load_store_size_in[1];

  // Lane offset with the bits that cannot be honoured forced to zero.
  assign off = is_byte ? alu_data_in[1:0] :
               is_half ? {alu_data_in[1], 1'b0} : 2'b00;

`ifdef MISALIGNED_TRAP_EN
  assign misaligned = (is_half & alu_data_in[0]) |
                      (is_word & |alu_data_in[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  assign mis_trap = valid_in & (load_in | store_in) &
                    ~exception_in & misaligned;

  assign start = valid_in & (load_in | store_in) & ~exception_in &
                 ~invalidate & ~misaligned & ~done_q &
                 (state_q == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      held_q  <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      held_q  <= held_d;
      wb_q    <= wb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start & ~bus.mem_ack) state_d = WAIT;
      WAIT: if (bus.mem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_req = ~reset &
                  (((state_q == IDLE) & start) | (state_q == WAIT));
    bus.mem_write  = store_in & ~reset;
    bus.mem_addr   = {alu_data_in[31:2], 2'b00};
    bus.mem_strobe = is_byte ? (4'b0001 << off) :
                     is_half ? (4'b0011 << off) : 4'b1111;
    bus.mem_wdata  = is_byte ? {4{rs2_data_in[7:0]}} :
                     is_half ? {2{rs2_data_in[15:0]}} : rs2_data_in;
    mem_busy = bus.mem_req & ~bus.mem_ack;
    ack_hit  = bus.mem_req & bus.mem_ack;
    capture  = ~stall & ~mem_busy;
  end

  always_comb begin
    shifted = bus.mem_rdata >> {off, 3'b000};
    ext = is_byte ? {{24{load_signed_in & shifted[7]}}, shifted[7:0]} :
          is_half ? {{16{load_signed_in & shifted[15]}}, shifted[15:0]} :
                    shifted;
    load_data = '0;
    if (load_in) load_data = done_q ? held_q : (ack_hit ? ext : 32'd0);
  end

  // Data acked under stall is parked until the MEM/WB register takes it.
  always_comb begin
    done_d = done_q;
    held_d = held_q;
    if (capture) begin
      done_d = 1'b0;
    end else if (ack_hit) begin
      done_d = 1'b1;
      held_d = ext;
    end
  end

  always_comb begin
    wb_d = wb_q;
    if (capture) begin
      wb_d.pc        = pc_in;
      wb_d.next_pc   = next_pc_in;
      wb_d.alu       = alu_data_in;
      wb_d.csr       = csr_data_in;
      wb_d.load_data = load_data;
      wb_d.branch    = branch_taken_in;
      wb_d.mret      = mret_in;
      wb_d.wfi       = wfi_in;
      wb_d.valid     = valid_in & ~invalidate;
      wb_d.exc       = exception_in | mis_trap;
      wb_d.wsel      = write_select_in;
      wb_d.rd        = rd_address_in;
      wb_d.csra      = csr_address_in;
      wb_d.ecause    = mis_trap ? (store_in ? 4'd6 : 4'd4) : ecause_in;
    end else if (~stall) begin
      wb_d.valid = 1'b0;
    end
  end

  assign pc_out           = wb_q.pc;
  assign next_pc_out      = wb_q.next_pc;
  assign alu_data_out     = wb_q.alu;
  assign csr_data_out     = wb_q.csr;
  assign load_data_out    = wb_q.load_data;
  assign branch_taken_out = wb_q.branch;
  assign mret_out         = wb_q.mret;
  assign wfi_out          = wb_q.wfi;
  assign valid_out        = wb_q.valid;
  assign exception_out    = wb_q.exc;
  assign write_select_out = wb_q.wsel;
  assign rd_address_out   = wb_q.rd;
  assign csr_address_out  = wb_q.csra;
  assign ecause_out       = wb_q.ecause;

endmodule

// File: tb/tb_memory.sv
// Bench for the MEM stage: directed cases plus random accesses
// checked against a byte-lane reference model.
module tb_memory;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in, next_pc_in, alu_data_in, rs2_data_in, csr_data_in;
  logic        branch_taken_in, load_in, store_in, load_signed_in;
  logic        mret_in, wfi_in, exception_in;
  logic [1:0]  load_store_size_in, write_select_in;
  logic [4:0]  rd_address_in;
  logic [11:0] csr_address_in;
  logic [3:0]  ecause_in;
  logic        valid_in, stall, invalidate;
  logic        mem_busy;
  logic [31:0] pc_out, next_pc_out, alu_data_out, csr_data_out;
  logic [31:0] load_data_out;
  logic        branch_taken_out, mret_out, wfi_out, valid_out, exception_out;
  logic [1:0]  write_select_out;
  logic [4:0]  rd_address_out;
  logic [11:0] csr_address_out;
  logic [3:0]  ecause_out;

  int total = 0;
  int bad = 0;

  memory_if bus ();

  memory dut (
    .clk(clk), .reset(reset),
    .pc_in(pc_in), .next_pc_in(next_pc_in), .alu_data_in(alu_data_in),
    .rs2_data_in(rs2_data_in), .csr_data_in(csr_data_in),
    .branch_taken_in(branch_taken_in), .load_in(load_in),
    .store_in(store_in), .load_signed_in(load_signed_in),
    .mret_in(mret_in), .wfi_in(wfi_in), .exception_in(exception_in),
    .load_store_size_in(load_store_size_in),
    .write_select_in(write_select_in), .rd_address_in(rd_address_in),
    .csr_address_in(csr_address_in), .ecause_in(ecause_in),
    .valid_in(valid_in), .stall(stall), .invalidate(invalidate),
    .mem_busy(mem_busy), .bus(bus.master),
    .pc_out(pc_out), .next_pc_out(next_pc_out),
    .alu_data_out(alu_data_out), .csr_data_out(csr_data_out),
    .load_data_out(load_data_out), .branch_taken_out(branch_taken_out),
    .mret_out(mret_out), .wfi_out(wfi_out), .valid_out(valid_out),
    .exception_out(exception_out), .write_select_out(write_select_out),
    .rd_address_out(rd_address_out), .csr_address_out(csr_address_out),
    .ecause_out(ecause_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic int lane(input logic [31:0] a, input logic [1:0] sz);
    int n = nbytes(sz);
    int lo = a % 4;
    return (lo / n) * n;
  endfunction

  function automatic logic [3:0] ref_strobe(input logic [31:0] a,
                                            input logic [1:0] sz);
    logic [3:0] s = '0;
    int n = nbytes(sz);
    int o = lane(a, sz);
    for (int b = 0; b < 4; b++) s[b] = (b >= o) && (b < o + n);
    return s;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] d,
                                            input logic [1:0] sz);
    logic [31:0] w;
    int n = nbytes(sz);
    for (int b = 0; b < 4; b++) w[8*b +: 8] = d[8*(b % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rd,
      input logic [31:0] a, input logic [1:0] sz, input bit sgn);
    logic [31:0] v = '0;
    int n = nbytes(sz);
    int o = lane(a, sz);
    for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(o + i) +: 8];
    if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  function automatic bit ref_mis(input logic [31:0] a, input logic [1:0] sz);
`ifdef MISALIGNED_TRAP_EN
    return (a % nbytes(sz)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic idle_inputs();
    valid_in = 0; load_in = 0; store_in = 0; exception_in = 0;
    invalidate = 0; stall = 0; bus.mem_ack = 0;
  endtask

  task automatic drive(input bit ld, input bit st, input bit sgn,
      input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    valid_in = 1; load_in = ld; store_in = st; load_signed_in = sgn;
    load_store_size_in = sz; alu_data_in = a; rs2_data_in = d;
    exception_in = 0; invalidate = 0; stall = 0;
    pc_in = $urandom; next_pc_in = $urandom; csr_data_in = $urandom;
    rd_address_in = 5'($urandom); ecause_in = 4'($urandom);
    write_select_in = 2'($urandom); csr_address_in = 12'($urandom);
    branch_taken_in = 1'($urandom); mret_in = 0; wfi_in = 0;
  endtask

  task automatic txn(input bit ld, input bit st, input bit sgn,
      input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
      input logic [31:0] rd, input int lat);
    bit mis, acc;
    logic [31:0] epc;
    logic [3:0] eec;
    logic [4:0] erd;
    drive(ld, st, sgn, sz, a, d);
    epc = pc_in; eec = ecause_in; erd = rd_address_in;
    mis = (ld || st) && ref_mis(a, sz);
    acc = (ld || st) && !mis;
    bus.mem_rdata = rd;
    bus.mem_ack = acc && (lat == 0);
    mid();
    chk("req", bus.mem_req, acc);
    if (acc) begin
      chk("addr", bus.mem_addr, {a[31:2], 2'b00});
      chk("write", bus.mem_write, st);
      chk("busy0", mem_busy, lat != 0);
      if (st) begin
        chk("strobe", bus.mem_strobe, ref_strobe(a, sz));
        chk("wdata", bus.mem_wdata, ref_wdata(d, sz));
      end
      for (int k = 1; k <= lat; k++) begin
        tick();
        chk("bubble", valid_out, 0);
        bus.mem_ack = (k == lat);
        mid();
        chk("req_hold", bus.mem_req, 1);
        chk("busy", mem_busy, k != lat);
      end
    end
    tick();
    bus.mem_ack = 0;
    bus.mem_rdata = $urandom;
    chk("valid_out", valid_out, 1);
    chk("pc_out", pc_out, epc);
    chk("rd_out", rd_address_out, erd);
    chk("load_data", load_data_out, (ld && acc) ? ref_load(rd, a, sz, sgn) : 0);
    chk("exc_out", exception_out, mis);
    chk("ecause", ecause_out, mis ? (st ? 4'd6 : 4'd4) : eec);
    idle_inputs();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, d, rd;
    logic [1:0] sz;
    int kind;

    reset = 1;
    idle_inputs();
    drive(1, 1, 1, 2'd2, 32'h100, 32'hDEAD_BEEF);
    bus.mem_rdata = 32'h1234_5678;
    tick(); tick();
    mid();
    chk("rst_req", bus.mem_req, 0);
    chk("rst_write", bus.mem_write, 0);
    chk("rst_busy", mem_busy, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_load", load_data_out, 0);
    chk("rst_exc", exception_out, 0);
    chk("rst_ecause", ecause_out, 0);
    chk("rst_branch", branch_taken_out, 0);
    tick();
    reset = 0;
    idle_inputs();
    tick();

    txn(1, 0, 1, 2'd0, 32'h1003, 32'h0, 32'h80FF_FFFF, 0);
    txn(0, 1, 0, 2'd1, 32'h2002, 32'h1234_ABCD, 32'h0, 3);
    txn(0, 1, 0, 2'd2, 32'h3001, 32'hCAFE_F00D, 32'h0, 1);
    txn(1, 0, 0, 2'd1, 32'h4006, 32'h0, 32'h8765_4321, 2);
    txn(0, 0, 0, 2'd2, 32'h5000, 32'h0, 32'h0, 0);

    drive(1, 0, 0, 2'd2, 32'h6000, 32'h0);
    exception_in = 1; ecause_in = 4'd5;
    bus.mem_ack = 0;
    mid();
    chk("exc_req", bus.mem_req, 0);
    tick();
    chk("exc_pass", exception_out, 1);
    chk("exc_cause", ecause_out, 5);
    chk("exc_valid", valid_out, 1);
    idle_inputs();

    rd = 32'h9ABC_DEF0;
    drive(1, 0, 0, 2'd2, 32'h7000, 32'h0);
    stall = 1;
    bus.mem_rdata = rd;
    mid();
    chk("st_req0", bus.mem_req, 1);
    tick();
    bus.mem_ack = 1;
    mid();
    chk("st_req1", bus.mem_req, 1);
    chk("st_busy1", mem_busy, 0);
    tick();
    bus.mem_ack = 0;
    bus.mem_rdata = 32'h0BAD_0BAD;
    mid();
    chk("st_req2", bus.mem_req, 0);
    tick();
    stall = 0;
    mid();
    chk("st_req3", bus.mem_req, 0);
    chk("st_busy3", mem_busy, 0);
    tick();
    chk("st_valid", valid_out, 1);
    chk("st_data", load_data_out, rd);
    idle_inputs();

    drive(1, 0, 0, 2'd2, 32'h8000, 32'h0);
    bus.mem_rdata = 32'h1111_2222;
    tick();
    invalidate = 1;
    mid();
    chk("inv_req1", bus.mem_req, 1);
    tick();
    mid();
    chk("inv_req2", bus.mem_req, 1);
    tick();
    bus.mem_ack = 1;
    mid();
    chk("inv_req3", bus.mem_req, 1);
    tick();
    bus.mem_ack = 0;
    chk("inv_valid", valid_out, 0);
    idle_inputs();
    mid();
    chk("inv_idle", bus.mem_req, 0);

    drive(0, 1, 0, 2'd2, 32'h9000, 32'h5555_AAAA);
    tick();
    reset = 1;
    mid();
    chk("rw_req", bus.mem_req, 0);
    tick();
    reset = 0;
    idle_inputs();
    mid();
    chk("rw_req_after", bus.mem_req, 0);
    chk("rw_busy", mem_busy, 0);
    chk("rw_valid", valid_out, 0);
    bus.mem_ack = 1;
    tick();
    bus.mem_ack = 0;
    chk("rw_stray", valid_out, 0);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      sz = 2'($urandom_range(0, 3));
      a = $urandom;
      d = $urandom;
      rd = $urandom;
      txn(kind == 0, kind == 1, 1'($urandom), sz, a, d, rd,
          $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
